// File: rtl/marker_run_detect.sv
// marker_run_detect
//
// Watches a stream of compressed pixel codes and reports horizontal runs of a
// marker colour. The marker code is captured at each line start. Every run of
// at least MIN_RUN consecutive marker pixels is reported with its start x and
// its length on the cycle after the pixel that ends it. At the end of each
// complete line, the number of qualifying runs in that line is published.
//
// Ports
//   clk_in         sole clock, rising edge
//   rst_in         asynchronous, active-high reset
//   pix_valid_in   qualifies code_in / line_start_in this cycle
//   line_start_in  current valid pixel is pixel 0 of a new line
//   code_in        3-bit compressed pixel code
//   target_in      marker code, sampled only on an accepted line start
//   run_valid_out  one-cycle pulse, run_x_out / run_len_out valid
//   run_x_out      x of first pixel of the reported run (held)
//   run_len_out    length of the reported run (held)
//   line_done_out  one-cycle pulse after the last pixel of a line
//   run_count_out  qualifying runs in the last completed line, saturating at 15

module marker_run_detect #(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned MIN_RUN    = 8,
  localparam int unsigned X_BITS    = $clog2(LINE_WIDTH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pix_valid_in,
  input  logic              line_start_in,
  input  logic [2:0]        code_in,
  input  logic [2:0]        target_in,
  output logic              run_valid_out,
  output logic [X_BITS-1:0] run_x_out,
  output logic [X_BITS-1:0] run_len_out,
  output logic              line_done_out,
  output logic [3:0]        run_count_out
);

  localparam logic [X_BITS-1:0] LastX   = X_BITS'(LINE_WIDTH - 1);
  localparam logic [X_BITS-1:0] MinRunX = X_BITS'(MIN_RUN);

  typedef enum logic [1:0] {
    StIdle,  // no line active
    StScan,  // in line, outside a run
    StRun    // in line, inside a marker run
  } state_e;

  // Line / run tracking state
  state_e            state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;          // x of the most recently accepted pixel
  logic [X_BITS-1:0] len_q, len_d;      // length of the open run
  logic [X_BITS-1:0] start_q, start_d;  // x of the first pixel of the open run
  logic [2:0]        target_q, target_d;
  logic [3:0]        cnt_q, cnt_d;      // qualifying runs so far in this line

  // Registered outputs
  logic              run_valid_q, run_valid_d;
  logic [X_BITS-1:0] run_x_q, run_x_d;
  logic [X_BITS-1:0] run_len_q, run_len_d;
  logic              line_done_q, line_done_d;
  logic [3:0]        run_count_q, run_count_d;

  // Per-pixel working values
  logic              active;       // this pixel belongs to a line
  logic              hit;          // this pixel matches the marker
  logic              last;         // this pixel is the final one of the line
  logic [2:0]        tgt;          // marker in force for this pixel
  logic [X_BITS-1:0] pix_x;        // x of this pixel
  logic [X_BITS-1:0] cur_len;      // run length including this pixel (0 if none)
  logic [X_BITS-1:0] cur_start;
  logic              close_en;     // the previously open run ends before this pixel
  logic              count_close;  // ...and it belongs to the line still in progress
  logic [X_BITS-1:0] close_len;
  logic [X_BITS-1:0] close_start;
  logic [3:0]        cnt_acc;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    len_d       = len_q;
    start_d     = start_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    run_valid_d = 1'b0;
    run_x_d     = run_x_q;
    run_len_d   = run_len_q;
    line_done_d = 1'b0;
    run_count_d = run_count_q;

    active      = 1'b0;
    hit         = 1'b0;
    last        = 1'b0;
    tgt         = target_q;
    pix_x       = '0;
    cur_len     = '0;
    cur_start   = '0;
    close_en    = 1'b0;
    count_close = 1'b0;
    close_len   = '0;
    close_start = '0;
    cnt_acc     = cnt_q;

    if (pix_valid_in) begin
      if (line_start_in) begin
        active  = 1'b1;
        tgt     = target_in;
        pix_x   = '0;
        cnt_acc = '0;
        // A run cut off by a new line is still reported, but the aborted line
        // never publishes a count, so it is not tallied.
        if (state_q == StRun) begin
          close_en    = 1'b1;
          close_len   = len_q;
          close_start = start_q;
        end
      end else if (state_q != StIdle) begin
        active = 1'b1;
        pix_x  = x_q + 1'b1;
        if ((state_q == StRun) && (code_in != target_q)) begin
          close_en    = 1'b1;
          count_close = 1'b1;
          close_len   = len_q;
          close_start = start_q;
        end
      end
    end

    hit = active && (code_in == tgt);

    if (hit) begin
      if ((state_q == StRun) && !line_start_in) begin
        cur_len   = len_q + 1'b1;
        cur_start = start_q;
      end else begin
        cur_len   = X_BITS'(1);
        cur_start = pix_x;
      end
    end

    if (close_en && (close_len >= MinRunX)) begin
      run_valid_d = 1'b1;
      run_x_d     = close_start;
      run_len_d   = close_len;
      if (count_close) begin
        cnt_acc = sat_inc(cnt_acc);
      end
    end

    if (active) begin
      last = (pix_x == LastX);

      // Only with a one-pixel line can both a closing report and an end-of-line
      // report land in the same cycle; the end-of-line run then wins.
      if (last && hit && (cur_len >= MinRunX)) begin
        run_valid_d = 1'b1;
        run_x_d     = cur_start;
        run_len_d   = cur_len;
        cnt_acc     = sat_inc(cnt_acc);
      end

      target_d = tgt;
      x_d      = pix_x;
      start_d  = cur_start;
      cnt_d    = cnt_acc;

      if (last) begin
        state_d     = StIdle;
        len_d       = '0;
        line_done_d = 1'b1;
        run_count_d = cnt_acc;
      end else if (hit) begin
        state_d = StRun;
        len_d   = cur_len;
      end else begin
        state_d = StScan;
        len_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      x_q         <= '0;
      len_q       <= '0;
      start_q     <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      run_valid_q <= 1'b0;
      run_x_q     <= '0;
      run_len_q   <= '0;
      line_done_q <= 1'b0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      len_q       <= len_d;
      start_q     <= start_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      run_valid_q <= run_valid_d;
      run_x_q     <= run_x_d;
      run_len_q   <= run_len_d;
      line_done_q <= line_done_d;
      run_count_q <= run_count_d;
    end
  end

  assign run_valid_out = run_valid_q;
  assign run_x_out     = run_x_q;
  assign run_len_out   = run_len_q;
  assign line_done_out = line_done_q;
  assign run_count_out = run_count_q;

endmodule

// File: tb/tb_marker_run_detect.sv
// Testbench for marker_run_detect (LINE_WIDTH=16, MIN_RUN=3).
// A line-buffer model finds runs by scanning back over stored codes; a
// negedge process compares every output each cycle, and directed literal
// checks pin the model on hand-worked cases.

module tb_marker_run_detect;

  localparam int LW   = 16;
  localparam int MINR = 3;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       pix_valid_in = 1'b0;
  logic       line_start_in = 1'b0;
  logic [2:0] code_in = 3'd0;
  logic [2:0] target_in = 3'd0;
  logic       run_valid_out;
  logic [4:0] run_x_out;
  logic [4:0] run_len_out;
  logic       line_done_out;
  logic [3:0] run_count_out;

  marker_run_detect #(
    .LINE_WIDTH(LW),
    .MIN_RUN   (MINR)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .pix_valid_in (pix_valid_in),
    .line_start_in(line_start_in),
    .code_in      (code_in),
    .target_in    (target_in),
    .run_valid_out(run_valid_out),
    .run_x_out    (run_x_out),
    .run_len_out  (run_len_out),
    .line_done_out(line_done_out),
    .run_count_out(run_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  // Model state
  bit m_active = 1'b0;
  int m_x = 0;
  int m_tgt = 0;
  int m_cnt = 0;
  int m_line[LW];
  // Expected outputs now, and pending for after the next edge
  int e_rv = 0, e_rx = 0, e_rl = 0, e_ld = 0, e_rc = 0;
  int n_rv = 0, n_rx = 0, n_rl = 0, n_ld = 0, n_rc = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endfunction

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("run_valid", 32'(run_valid_out), 32'(e_rv));
      check("run_x", 32'(run_x_out), 32'(e_rx));
      check("run_len", 32'(run_len_out), 32'(e_rl));
      check("line_done", 32'(line_done_out), 32'(e_ld));
      check("run_count", 32'(run_count_out), 32'(e_rc));
    end
  end

  // Run ends at last_x: walk back over marker codes to find where it began.
  task automatic close_run(input int last_x, input bit count);
    int s;
    s = last_x;
    while (s > 0 && m_line[s-1] == m_tgt) s--;
    if (last_x - s + 1 >= MINR) begin
      n_rv = 1;
      n_rx = s;
      n_rl = last_x - s + 1;
      if (count && m_cnt < 15) m_cnt++;
    end
  endtask

  task automatic model_pixel(input bit s, input int c, input int t);
    if (s) begin
      if (m_active && m_x > 0 && m_line[m_x-1] == m_tgt) close_run(m_x - 1, 1'b0);
      m_tgt    = t;
      m_x      = 0;
      m_cnt    = 0;
      m_active = 1'b1;
    end
    if (!m_active) return;
    m_line[m_x] = c;
    if (!s && c != m_tgt && m_x > 0 && m_line[m_x-1] == m_tgt) close_run(m_x - 1, 1'b1);
    if (m_x == LW - 1) begin
      if (c == m_tgt) close_run(m_x, 1'b1);
      n_ld     = 1;
      n_rc     = m_cnt;
      m_active = 1'b0;
    end else begin
      m_x++;
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_x = 0; m_tgt = 0; m_cnt = 0;
    e_rv = 0; e_rx = 0; e_rl = 0; e_ld = 0; e_rc = 0;
  endtask

  // One clock: drive a pixel (or an idle cycle), advance model, settle.
  task automatic px(input bit v, input bit s, input int c, input int t);
    pix_valid_in  = v;
    line_start_in = s;
    code_in       = 3'(c);
    target_in     = 3'(t);
    n_rv = 0; n_ld = 0; n_rx = e_rx; n_rl = e_rl; n_rc = e_rc;
    if (v) model_pixel(s, c, t);
    @(posedge clk_in);
    #1;
    e_rv = n_rv; e_rx = n_rx; e_rl = n_rl; e_ld = n_ld; e_rc = n_rc;
    pix_valid_in  = 1'b0;
    line_start_in = 1'b0;
  endtask

  task automatic send(input int tgt, input int c[LW], input int lo, input int hi);
    for (int i = lo; i <= hi; i++) px(1'b1, i == 0, c[i], tgt);
  endtask

  task automatic lit(input string name, input int rv, input int rx, input int rl,
                     input int ld, input int rc);
    check({name, ".rv"}, 32'(run_valid_out), 32'(rv));
    if (rv != 0) begin
      check({name, ".rx"}, 32'(run_x_out), 32'(rx));
      check({name, ".rl"}, 32'(run_len_out), 32'(rl));
    end
    check({name, ".ld"}, 32'(line_done_out), 32'(ld));
    if (ld != 0 || rc >= 0) check({name, ".rc"}, 32'(run_count_out), 32'(rc));
  endtask

  task automatic reset_pulse();
    rst_in = 1'b1;
    model_reset();
    #1;
    check("rst.rv", 32'(run_valid_out), 32'd0);
    check("rst.rx", 32'(run_x_out), 32'd0);
    check("rst.rl", 32'(run_len_out), 32'd0);
    check("rst.ld", 32'(line_done_out), 32'd0);
    check("rst.rc", 32'(run_count_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    int c[LW];
    #1;
    reset_pulse();
    chk_en = 1'b1;

    // Non-start pixels before any line are ignored
    for (int i = 0; i < 3; i++) px(1'b1, 1'b0, 5, 5);
    lit("pre", 0, 0, 0, 0, 0);

    // Run of 4 at x=2, closed by x=6
    c = '{0, 0, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send(5, c, 0, 6);
    lit("s1.close", 1, 2, 4, 0, 0);
    send(5, c, 7, 15);
    lit("s1.done", 0, 0, 0, 1, 1);

    // Short run dropped, run of 3 at x=9 reported
    c = '{0, 0, 0, 0, 3, 3, 0, 0, 0, 3, 3, 3, 0, 0, 0, 0};
    send(3, c, 0, 6);
    lit("s2.short", 0, 0, 0, 0, 1);
    send(3, c, 7, 12);
    lit("s2.close", 1, 9, 3, 0, 1);
    send(3, c, 13, 15);
    lit("s2.done", 0, 0, 0, 1, 1);

    // Run at x=13..15 closed by the end of line
    c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 7};
    send(7, c, 0, 15);
    lit("s3.done", 1, 13, 3, 1, 1);

    // Run x=0..9 aborted by a new line at old x=10
    c = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0};
    send(2, c, 0, 9);
    px(1'b1, 1'b1, 0, 2);
    lit("s4.abort", 1, 0, 10, 0, 1);
    c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send(2, c, 1, 15);
    lit("s4.done", 0, 0, 0, 1, 0);

    // Gapped valid through a run of 4 at x=3
    px(1'b1, 1'b1, 0, 4);
    px(1'b1, 1'b0, 0, 4);
    px(1'b1, 1'b0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      px(1'b1, 1'b0, 4, 4);
      px(1'b0, 1'b0, 4, 4);
    end
    px(1'b1, 1'b0, 0, 4);
    lit("s5.close", 1, 3, 4, 0, 0);
    for (int i = 8; i < 15; i++) px(1'b1, 1'b0, 0, 4);
    lit("s5.x14", 0, 0, 0, 0, 0);
    px(1'b1, 1'b0, 0, 4);
    lit("s5.done", 0, 0, 0, 1, 1);

    // Full-line run
    c = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
    send(6, c, 0, 15);
    lit("s6.full", 1, 0, 16, 1, 1);

    // Four runs in one line; target_in changes after the start are ignored
    px(1'b1, 1'b1, 1, 1);
    c = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    for (int i = 1; i < LW; i++) px(1'b1, 1'b0, c[i], 0);
    lit("s7.done", 1, 12, 3, 1, 4);

    // Reset mid-run at x=7: nothing reported, stream ignored until a new line
    c = '{5, 5, 5, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    send(5, c, 0, 7);
    reset_pulse();
    for (int i = 0; i < 10; i++) px(1'b1, 1'b0, 5, 5);
    lit("s8.ignored", 0, 0, 0, 0, 0);
    c = '{5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send(5, c, 0, 4);
    lit("s8.recover", 1, 0, 4, 0, 0);
    send(5, c, 5, 15);
    lit("s8.done", 0, 0, 0, 1, 1);

    px(1'b0, 1'b0, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
